output_writer: RTL and testbench
================================

Name: output_writer

Overview:
- Responder on the write-output handshake of the layer controller FSM. On a write_output_en pulse it captures the accumulator array result and requantizes each lane from ACC_W to OUT_W.
- Writes the lanes one per accepted beat into output memory through a valid/ready write port, then pulses write_output_done.
- Counts tiles per layer and drives is_last back to the controller.

Parameters:
NUM_LANES, 4, accumulator lanes per tile
ACC_W, 24, signed accumulator width per lane
OUT_W, 8, signed output width
SHIFT, 8, arithmetic right shift applied before saturation
ADDR_W, 10, output memory address width
NUM_TILES, 3, tiles per layer (>=1)
BASE_ADDR, 0, first output address of a layer

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous active-low reset
layer_start  in  1  pulse: clear tile counter, address pointer, is_last
write_output_en  in  1  pulse from controller: write current tile
acc_data  in  NUM_LANES*ACC_W  lane i = acc_data[i*ACC_W +: ACC_W], signed
mem_ready  in  1  memory accepts beat when mem_we && mem_ready
mem_we  out  1  write request valid
mem_addr  out  ADDR_W  write address
mem_wdata  out  OUT_W  requantized lane value
write_output_done  out  1  one-cycle pulse, tile fully written
is_last  out  1  high once NUM_TILES tiles written; held until layer_start/reset
busy  out  1  high in WRITE and DONE

Behaviour:
- One clock; reset is synchronous and active-low (clk, rstn). Reset forces state IDLE. Clears all outputs to 0, tile_cnt=0, addr_ptr=BASE_ADDR, lane_cnt=0, snapshot=0.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - On write_output_en=1 and is_last=0: register acc_data into the snapshot, set lane_cnt=0, go to WRITE.
  - On write_output_en with is_last=1: ignore; no memory traffic, no done pulse.
- WRITE:
  - Outputs: mem_we=1, mem_addr=addr_ptr, mem_wdata=q(snapshot lane lane_cnt).
  - On mem_we && mem_ready: addr_ptr+1 (modulo 2^ADDR_W, natural wrap) and lane_cnt+1.
  - When the accepted beat is lane NUM_LANES-1, go to DONE.
  - While mem_ready=0, hold addr and data stable.
- DONE:
  - write_output_done=1 for exactly this cycle; mem_we=0.
  - tile_cnt+1 (saturates at NUM_TILES). is_last is set in the same cycle as the done pulse when the new tile_cnt equals NUM_TILES.
  - Next state IDLE.
- Latency with mem_ready tied to 1:
  - en sampled at cycle 0.
  - Lanes on cycles 1..NUM_LANES.
  - done at cycle NUM_LANES+1.
  - Next en is accepted at NUM_LANES+2.
  - Each low cycle of mem_ready during WRITE adds one cycle.
- Requantization q(x):
  - y = x >>> SHIFT (arithmetic).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Output two's complement, OUT_W bits.
- write_output_en while busy=1: ignored; the snapshot is not overwritten.
- layer_start in WRITE/DONE:
  - Abort to IDLE next cycle; mem_we=0 from that cycle.
  - No done pulse; tile_cnt=0, addr_ptr=BASE_ADDR, is_last=0.
- layer_start and write_output_en in the same IDLE cycle: counters cleared and the write is accepted as tile 0 at BASE_ADDR.
- Reset mid-operation: same as reset, with no done pulse.
- acc_data is sampled only in the capture cycle; later changes do not affect the written data.

Test Plan:
1. Reset: rstn=0 for 4 cycles with random inputs -> mem_we, write_output_done, is_last and busy are all 0; the first write later starts at addr 0.
2. Single tile, mem_ready=1, lanes 0x000100, 0x000A00, 0x7FFFFF, 0xFF8000:
   - Writes (0,0x01), (1,0x0A), (2,0x7F), (3,0x80) on cycles 1-4.
   - write_output_done on cycle 5 only.
3. Backpressure: mem_ready=0 for 3 cycles while lane 2 is presented:
   - addr 2 and its data held stable.
   - done delayed to cycle 8; no duplicate or skipped address.
4. Three tiles, then a fourth en:
   - Addresses 0..11 written; is_last rises with the third done and stays high.
   - Fourth en produces no mem_we.
   - layer_start then clears is_last; the next tile is written at addr 0.
5. Abort: layer_start while lane 1 is being written:
   - mem_we=0 next cycle; no done pulse.
   - Next tile starts at BASE_ADDR with is_last=0.
6. Corner cases:
   - write_output_en pulsed during WRITE is ignored; the written data matches the first snapshot.
   - With ADDR_W=4, BASE_ADDR=14: addresses 14, 15, 0, 1.

Source files
------------

// File: rtl/output_writer_if.sv
// Output-memory write port: valid/ready beat carrying one requantized lane.
interface output_writer_if #(
    parameter int ADDR_W = 10,
    parameter int OUT_W  = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [OUT_W-1:0]  mem_wdata;
    logic              mem_ready;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/output_writer.sv
// Captures an accumulator tile, requantizes each lane to OUT_W and writes the
// lanes one beat at a time to output memory; tracks tiles per layer for is_last.
module output_writer #(
    parameter int NUM_LANES = 4,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 8,
    parameter int ADDR_W    = 10,
    parameter int NUM_TILES = 3,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       layer_start,
    input  logic                       write_output_en,
    input  logic [NUM_LANES*ACC_W-1:0] acc_data,
    output_writer_if.master            mem,
    output logic                       write_output_done,
    output logic                       is_last,
    output logic                       busy
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TILE_W = $clog2(NUM_TILES + 1);

    localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [TILE_W-1:0]       TILE_MAX  = TILE_W'(NUM_TILES);
    localparam logic [ADDR_W-1:0]       BASE      = ADDR_W'(BASE_ADDR);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t              state_reg, state_next;
    logic [LANE_W-1:0]   lane_reg, lane_next;
    logic [TILE_W-1:0]   tile_reg, tile_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                is_last_reg, is_last_next;
    logic                capture;

    logic signed [ACC_W-1:0] snap_reg [NUM_LANES];
    logic [OUT_W-1:0]        q_lane   [NUM_LANES];

    // Requantize every snapshot lane in parallel; the beat just selects one.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic signed [ACC_W-1:0] shifted;
            assign shifted = snap_reg[gi] >>> SHIFT;
            assign q_lane[gi] = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                                (shifted < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                                      shifted[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_LANES; i++) snap_reg[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_LANES; i++) snap_reg[i] <= acc_data[i*ACC_W +: ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            lane_reg    <= '0;
            tile_reg    <= '0;
            addr_reg    <= BASE;
            is_last_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lane_reg    <= lane_next;
            tile_reg    <= tile_next;
            addr_reg    <= addr_next;
            is_last_reg <= is_last_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lane_next    = lane_reg;
        tile_next    = tile_reg;
        addr_next    = addr_reg;
        is_last_next = is_last_reg;
        capture      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (layer_start) begin
                    tile_next    = '0;
                    addr_next    = BASE;
                    is_last_next = 1'b0;
                end
                // A simultaneous layer_start clears is_last, so the write is tile 0.
                if (write_output_en && (layer_start || !is_last_reg)) begin
                    capture    = 1'b1;
                    lane_next  = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (layer_start) begin
                    tile_next    = '0;
                    addr_next    = BASE;
                    is_last_next = 1'b0;
                    state_next   = IDLE;
                end else if (mem.mem_ready) begin
                    addr_next = addr_reg + ADDR_W'(1);
                    lane_next = lane_reg + LANE_W'(1);
                    if (lane_reg == LAST_LANE) begin
                        state_next = DONE;
                        if (tile_reg != TILE_MAX) begin
                            tile_next    = tile_reg + TILE_W'(1);
                            is_last_next = (tile_reg + TILE_W'(1) == TILE_MAX);
                        end
                    end
                end
            end
            DONE: begin
                if (layer_start) begin
                    tile_next    = '0;
                    addr_next    = BASE;
                    is_last_next = 1'b0;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem.mem_we         = (state_reg == WRITE);
    assign mem.mem_addr       = addr_reg;
    assign mem.mem_wdata      = q_lane[lane_reg];
    assign write_output_done  = (state_reg == DONE) && !layer_start;
    assign busy               = (state_reg != IDLE);
    assign is_last            = is_last_reg;
endmodule

// File: tb/tb_output_writer.sv
// Randomized bench for output_writer with a floor-divide/clamp reference model.
module tb_output_writer;
    localparam int NL     = 4;
    localparam int ACC_W  = 24;
    localparam int SHIFT  = 8;
    localparam int NT     = 3;
    localparam int BUDGET = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn = 1'b0, layer_start = 1'b0, en = 1'b0, mem_ready = 1'b1;
    logic [NL*ACC_W-1:0] acc_data = '0;
    logic done, is_last, busy, done2, is_last2, busy2;

    output_writer_if #(.ADDR_W(10), .OUT_W(8)) mif ();
    output_writer_if #(.ADDR_W(4),  .OUT_W(8)) mif2 ();
    assign mif.mem_ready  = mem_ready;
    assign mif2.mem_ready = mem_ready;

    output_writer dut (
        .clk(clk), .rstn(rstn), .layer_start(layer_start), .write_output_en(en),
        .acc_data(acc_data), .mem(mif), .write_output_done(done),
        .is_last(is_last), .busy(busy)
    );

    output_writer #(.ADDR_W(4), .BASE_ADDR(14)) dut2 (
        .clk(clk), .rstn(rstn), .layer_start(layer_start), .write_output_en(en),
        .acc_data(acc_data), .mem(mif2), .write_output_done(done2),
        .is_last(is_last2), .busy(busy2)
    );

    typedef struct {int addr; int data; int cyc;} beat_t;
    beat_t beats[$];
    int    beats2[$];
    int    dones[$];
    bit    done_last[$];
    int    cyc = 0, we_cnt = 0, dones2 = 0, we_base = 0, d2_base = 0;
    bit    busy_log[int];
    int    addr_log[int];
    int    data_log[int];
    int    rdy_hist[64];
    int    checks = 0, errors = 0;
    int    m_addr = 0, m_tiles = 0;
    bit    m_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mif.mem_we === 1'b1) we_cnt <= we_cnt + 1;
        if (mif.mem_we === 1'b1 && mem_ready === 1'b1)
            beats.push_back('{int'(mif.mem_addr), int'(mif.mem_wdata), cyc});
        if (done === 1'b1) begin
            dones.push_back(cyc);
            done_last.push_back(is_last);
        end
        if (mif2.mem_we === 1'b1 && mem_ready === 1'b1) beats2.push_back(int'(mif2.mem_addr));
        if (done2 === 1'b1) dones2 <= dones2 + 1;
        busy_log[cyc] = busy;
        addr_log[cyc] = int'(mif.mem_addr);
        data_log[cyc] = int'(mif.mem_wdata);
    end

    // Reference requantization: floor(x / 2^SHIFT) clamped to the signed 8-bit range.
    function automatic int q_ref(input logic [ACC_W-1:0] x);
        longint v, y, d;
        v = longint'($signed(x));
        d = longint'(1) << SHIFT;
        y = (v >= 0) ? v / d : -((-v + d - 1) / d);
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return int'(y) & 255;
    endfunction

    function automatic int lane_of(input logic [NL*ACC_W-1:0] acc, input int i);
        return q_ref(acc[i*ACC_W +: ACC_W]);
    endfunction

    // Relative cycle on which lane i is accepted: the (i+1)-th ready cycle from cycle 1.
    function automatic int exp_accept(input int lane);
        int n = 0;
        for (int r = 1; r < 64; r++) begin
            if (rdy_hist[r] != 0) begin
                if (n == lane) return r;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic logic [NL*ACC_W-1:0] rand_acc();
        return {$urandom, $urandom, $urandom};
    endfunction

    // mode 0: ready always high; 1: low for stall_n cycles from lane stall_lane; 2: random.
    task automatic drive_tile(input logic [NL*ACC_W-1:0] acc, input int mode, input int stall_lane,
                              input int stall_n, input int inject_rel, input int abort_rel,
                              output int en_c);
        @(posedge clk); #1;
        beats.delete(); beats2.delete(); dones.delete(); done_last.delete();
        we_base = we_cnt; d2_base = dones2;
        for (int r = 0; r < 64; r++) rdy_hist[r] = 0;
        en = 1'b1; acc_data = acc; mem_ready = 1'b1; en_c = cyc;
        for (int r = 1; r <= BUDGET; r++) begin
            @(posedge clk); #1;
            en          = (r == inject_rel);
            layer_start = (r == abort_rel);
            acc_data    = rand_acc();
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (r > stall_lane && r <= stall_lane + stall_n) ? 1'b0 : 1'b1;
                default: mem_ready = (r >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            rdy_hist[r] = int'(mem_ready);
        end
        @(posedge clk); #1;
        en = 1'b0; layer_start = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic pulse_layer_start();
        @(posedge clk); #1; layer_start = 1'b1;
        @(posedge clk); #1; layer_start = 1'b0;
        m_addr = 0; m_tiles = 0; m_last = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rstn = 1'b0; layer_start = 1'($urandom); en = 1'($urandom);
            mem_ready = 1'($urandom); acc_data = rand_acc();
        end
        @(negedge clk);
        checks++; if (mif.mem_we !== 1'b0)  begin errors++; $display("FAIL reset_mem_we got %b want 0", mif.mem_we); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (is_last !== 1'b0)     begin errors++; $display("FAIL reset_is_last got %b want 0", is_last); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mif2.mem_we !== 1'b0 || is_last2 !== 1'b0 || busy2 !== 1'b0)
            begin errors++; $display("FAIL reset_dut2 we=%b last=%b busy=%b want 0", mif2.mem_we, is_last2, busy2); end
        @(posedge clk); #1;
        rstn = 1'b1; en = 1'b0; layer_start = 1'b0; mem_ready = 1'b1;
        m_addr = 0; m_tiles = 0; m_last = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_single();
        logic [NL*ACC_W-1:0] acc;
        int exp_d[4];
        int en_c;
        acc = {24'hFF8000, 24'h7FFFFF, 24'h000A00, 24'h000100};
        exp_d = '{32'h01, 32'h0A, 32'h7F, 32'h80};
        drive_tile(acc, 0, 0, 0, 0, 0, en_c);
        checks++; if (beats.size() != 4) begin errors++; $display("FAIL single_count got %0d want 4", beats.size()); end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checks++;
            if (beats[i].addr != i || beats[i].data != exp_d[i] || beats[i].cyc - en_c != i + 1) begin
                errors++;
                $display("FAIL single_beat%0d got addr=%0d data=%02h cyc=%0d want addr=%0d data=%02h cyc=%0d",
                         i, beats[i].addr, beats[i].data, beats[i].cyc - en_c, i, exp_d[i], i + 1);
            end
        end
        checks++;
        if (dones.size() != 1 || dones[0] - en_c != 5) begin
            errors++; $display("FAIL single_done got %0d pulses (first rel %0d) want 1 at 5",
                               dones.size(), (dones.size() > 0) ? dones[0] - en_c : -1);
        end
        checks++;
        if (busy_log[en_c + 1] !== 1'b1 || busy_log[en_c + 5] !== 1'b1 || busy_log[en_c + 6] !== 1'b0) begin
            errors++; $display("FAIL single_busy got c1=%b c5=%b c6=%b want 1 1 0",
                               busy_log[en_c + 1], busy_log[en_c + 5], busy_log[en_c + 6]);
        end
        m_addr = 4; m_tiles = 1;
        $display("single: %0d beats, done pulses %0d", beats.size(), dones.size());
    endtask

    task automatic test_backpressure();
        logic [NL*ACC_W-1:0] acc;
        int en_c;
        pulse_layer_start();
        acc = rand_acc();
        drive_tile(acc, 1, 2, 3, 0, 0, en_c);
        checks++; if (beats.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", beats.size()); end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checks++;
            if (beats[i].addr != i || beats[i].data != lane_of(acc, i) || beats[i].cyc - en_c != exp_accept(i)) begin
                errors++;
                $display("FAIL bp_beat%0d got addr=%0d data=%02h cyc=%0d want addr=%0d data=%02h cyc=%0d",
                         i, beats[i].addr, beats[i].data, beats[i].cyc - en_c, i, lane_of(acc, i), exp_accept(i));
            end
        end
        for (int r = 3; r <= 5; r++) begin
            checks++;
            if (addr_log[en_c + r] != 2 || data_log[en_c + r] != lane_of(acc, 2)) begin
                errors++; $display("FAIL bp_hold_c%0d got addr=%0d data=%02h want addr=2 data=%02h",
                                   r, addr_log[en_c + r], data_log[en_c + r], lane_of(acc, 2));
            end
        end
        checks++;
        if (dones.size() != 1 || dones[0] - en_c != 8) begin
            errors++; $display("FAIL bp_done got %0d pulses (first rel %0d) want 1 at 8",
                               dones.size(), (dones.size() > 0) ? dones[0] - en_c : -1);
        end
        m_addr = 4; m_tiles = 1;
        $display("backpressure: %0d beats, done rel %0d", beats.size(), (dones.size() > 0) ? dones[0] - en_c : -1);
    endtask

    task automatic test_three_tiles();
        logic [NL*ACC_W-1:0] acc;
        int en_c;
        pulse_layer_start();
        for (int t = 0; t < NT; t++) begin
            acc = rand_acc();
            drive_tile(acc, 2, 0, 0, 0, 0, en_c);
            checks++; if (beats.size() != NL) begin errors++; $display("FAIL tiles_count t%0d got %0d want %0d", t, beats.size(), NL); end
            for (int i = 0; i < beats.size() && i < NL; i++) begin
                checks++;
                if (beats[i].addr != (m_addr + i) % 1024 || beats[i].data != lane_of(acc, i) ||
                    beats[i].cyc - en_c != exp_accept(i)) begin
                    errors++;
                    $display("FAIL tiles_t%0d_beat%0d got addr=%0d data=%02h cyc=%0d want addr=%0d data=%02h cyc=%0d",
                             t, i, beats[i].addr, beats[i].data, beats[i].cyc - en_c,
                             (m_addr + i) % 1024, lane_of(acc, i), exp_accept(i));
                end
            end
            m_addr = (m_addr + NL) % 1024; m_tiles++; m_last = (m_tiles == NT);
            checks++;
            if (dones.size() != 1 || dones[0] - en_c != exp_accept(NL - 1) + 1 || done_last[0] != m_last) begin
                errors++; $display("FAIL tiles_done t%0d got pulses=%0d rel=%0d last=%0d want 1 at %0d last=%0d",
                                   t, dones.size(), (dones.size() > 0) ? dones[0] - en_c : -1,
                                   (done_last.size() > 0) ? int'(done_last[0]) : -1, exp_accept(NL - 1) + 1, m_last);
            end
            $display("tiles: tile %0d written at %0d..%0d", t, m_addr - NL, m_addr - 1);
        end
        drive_tile(rand_acc(), 0, 0, 0, 0, 0, en_c);
        checks++;
        if (we_cnt - we_base != 0 || dones.size() != 0) begin
            errors++; $display("FAIL tiles_fourth got we_cycles=%0d dones=%0d want 0 0", we_cnt - we_base, dones.size());
        end
        checks++; if (is_last !== 1'b1) begin errors++; $display("FAIL tiles_is_last_hold got %b want 1", is_last); end
        pulse_layer_start();
        @(negedge clk);
        checks++; if (is_last !== 1'b0) begin errors++; $display("FAIL tiles_is_last_clear got %b want 0", is_last); end
        acc = rand_acc();
        drive_tile(acc, 0, 0, 0, 0, 0, en_c);
        checks++;
        if (beats.size() != NL || beats[0].addr != 0 || beats[0].data != lane_of(acc, 0)) begin
            errors++; $display("FAIL tiles_restart got count=%0d addr0=%0d want count=%0d addr0=0",
                               beats.size(), (beats.size() > 0) ? beats[0].addr : -1, NL);
        end
        $display("tiles: fourth en ignored, restart at addr %0d", (beats.size() > 0) ? beats[0].addr : -1);
    endtask

    task automatic test_abort();
        logic [NL*ACC_W-1:0] acc;
        int en_c;
        pulse_layer_start();
        acc = rand_acc();
        drive_tile(acc, 0, 0, 0, 0, 2, en_c);
        checks++;
        if (we_cnt - we_base != 2 || beats.size() != 2) begin
            errors++; $display("FAIL abort_we got we_cycles=%0d beats=%0d want 2 2", we_cnt - we_base, beats.size());
        end
        checks++; if (dones.size() != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", dones.size()); end
        checks++; if (busy_log[en_c + 3] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_log[en_c + 3]); end
        m_addr = 0; m_tiles = 0; m_last = 1'b0;
        acc = rand_acc();
        drive_tile(acc, 0, 0, 0, 0, 0, en_c);
        checks++;
        if (beats.size() != NL || beats[0].addr != 0 || dones.size() != 1 || done_last[0] != 1'b0) begin
            errors++; $display("FAIL abort_next got count=%0d addr0=%0d dones=%0d want %0d 0 1 with is_last 0",
                               beats.size(), (beats.size() > 0) ? beats[0].addr : -1, dones.size(), NL);
        end
        $display("abort: next tile starts at %0d", (beats.size() > 0) ? beats[0].addr : -1);
    endtask

    task automatic test_inject();
        logic [NL*ACC_W-1:0] acc;
        int en_c;
        pulse_layer_start();
        acc = rand_acc();
        drive_tile(acc, 0, 0, 0, 2, 0, en_c);
        for (int i = 0; i < beats.size() && i < NL; i++) begin
            checks++;
            if (beats[i].data != lane_of(acc, i)) begin
                errors++; $display("FAIL inject_beat%0d got %02h want %02h", i, beats[i].data, lane_of(acc, i));
            end
        end
        checks++;
        if (we_cnt - we_base != NL || dones.size() != 1) begin
            errors++; $display("FAIL inject_count got we_cycles=%0d dones=%0d want %0d 1", we_cnt - we_base, dones.size(), NL);
        end
        $display("inject: en during write ignored, %0d beats", beats.size());
    endtask

    task automatic test_wrap();
        int exp_a[4];
        int en_c;
        exp_a = '{14, 15, 0, 1};
        pulse_layer_start();
        drive_tile(rand_acc(), 0, 0, 0, 0, 0, en_c);
        checks++; if (beats2.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", beats2.size()); end
        for (int i = 0; i < beats2.size() && i < 4; i++) begin
            checks++;
            if (beats2[i] != exp_a[i]) begin
                errors++; $display("FAIL wrap_addr%0d got %0d want %0d", i, beats2[i], exp_a[i]);
            end
        end
        checks++; if (dones2 - d2_base != 1) begin errors++; $display("FAIL wrap_done got %0d want 1", dones2 - d2_base); end
        $display("wrap: %0d beats from base 14", beats2.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_three_tiles();
        test_abort();
        test_inject();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
